jamma_input_scanner: RTL and testbench



---
 rtl/jamma_pkg.sv | 19 +
 rtl/debounce_bit.sv | 60 ++++++
 rtl/jamma_input_scanner.sv | 163 ++++++++++++++++
 tb/tb_jamma_input_scanner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/jamma_pkg.sv
// Shared types and constants for the JAMMA player-input scanner.
package jamma_pkg;

    typedef enum logic [1:0] {
        P1_WAIT = 2'd0,
        P1_CAP  = 2'd1,
        P2_WAIT = 2'd2,
        P2_CAP  = 2'd3
    } scan_state_t;

    localparam logic [7:0] JOY_IDLE  = 8'hFF;
    localparam logic [1:0] COIN_IDLE = 2'b11;

    // Clocks per full two-player scan: each player gets a settle window plus one capture clock.
    function automatic int unsigned scan_period(input int unsigned settle_cycles);
        return 2 * (settle_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounced input bit: the output follows the input only after DEPTH identical scan samples.
module debounce_bit #(
    parameter int unsigned DEPTH = 3
) (
    input  logic CLK,
    input  logic reset,
    input  logic en,
    input  logic din,
    output logic q,
    output logic q_next_c
);

    logic deb_q, deb_d;
    logic stable_c;

    // The newest sample joins the stored DEPTH-1 older ones to form the full window.
    if (DEPTH == 1) begin : g_single
        assign stable_c = 1'b1;
    end else begin : g_hist
        logic [DEPTH-2:0] hist_q, hist_d;
        logic [DEPTH-1:0] window_c;

        assign window_c = {hist_q, din};
        assign stable_c = (window_c == {DEPTH{din}});

        always_comb begin
            hist_d = hist_q;
            if (en) begin
                hist_d = window_c[DEPTH-2:0];
            end
        end

        always_ff @(posedge CLK) begin
            if (reset) begin
                hist_q <= '1;
            end else begin
                hist_q <= hist_d;
            end
        end
    end

    always_comb begin
        deb_d = deb_q;
        if (en && stable_c) begin
            deb_d = din;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            deb_q <= 1'b1;
        end else begin
            deb_q <= deb_d;
        end
    end

    assign q        = deb_q;
    assign q_next_c = deb_d;

endmodule

// File: rtl/jamma_input_scanner.sv
// Scans the shared JAMMA player mux, debounces both players and the coin switches,
// and stretches accepted coin presses into fixed-length pulses.
module jamma_input_scanner
    import jamma_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = 4,
    parameter int unsigned DEBOUNCE_SCANS  = 3,
    parameter int unsigned COIN_HOLD_SCANS = 8
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [7:0] JJOY,
    input  logic [1:0] JCOIN,
    input  logic [5:0] kbd_joy,
    output logic       JSELECT,
    output logic [7:0] joystick1,
    output logic [7:0] joystick2,
    output logic [1:0] coin,
    output logic       scan_tick
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int unsigned CW = $clog2(COIN_HOLD_SCANS) + 1;
    localparam int unsigned NB = 18;

    scan_state_t   state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          jselect_q, jselect_d;
    logic [7:0]    raw1_q, raw1_d;
    logic [7:0]    raw2_q, raw2_d;
    logic [1:0]    rawc_q, rawc_d;
    logic          tick_q, tick_d;
    logic [7:0]    joy1_q, joy1_d;
    logic [7:0]    joy2_q, joy2_d;
    logic [1:0]    coin_q, coin_d;
    logic [CW-1:0] coin_cnt_q [2];
    logic [CW-1:0] coin_cnt_d [2];

    logic [NB-1:0] samp_c;
    logic [NB-1:0] deb;
    logic [NB-1:0] deb_next;
    logic [NB-1:0] deb_now_c;
    logic [1:0]    deb_c;
    logic [1:0]    deb_c_next;

    // Scan sequencer: settle, capture player 1, settle, capture player 2.
    always_comb begin : scan_fsm
        state_d = state_q;
        cnt_d   = cnt_q;
        raw1_d  = raw1_q;
        raw2_d  = raw2_q;
        rawc_d  = rawc_q;
        unique case (state_q)
            P1_WAIT: begin
                if (cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = P1_CAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            P1_CAP: begin
                raw1_d  = JJOY;
                state_d = P2_WAIT;
            end
            P2_WAIT: begin
                if (cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = P2_CAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            P2_CAP: begin
                raw2_d  = JJOY;
                rawc_d  = JCOIN;
                state_d = P1_WAIT;
            end
            default: state_d = P1_WAIT;
        endcase
        jselect_d = (state_d == P2_WAIT) || (state_d == P2_CAP);
        tick_d    = (state_q == P2_CAP);
    end

    assign samp_c = {rawc_q, raw2_q, raw1_q};

    for (genvar i = 0; i < NB; i++) begin : g_deb
        debounce_bit #(
            .DEPTH(DEBOUNCE_SCANS)
        ) u_deb (
            .CLK     (CLK),
            .reset   (reset),
            .en      (tick_q),
            .din     (samp_c[i]),
            .q       (deb[i]),
            .q_next_c(deb_next[i])
        );
    end

    // Off-tick the two are equal; taking the next value on the tick avoids a clock of lag.
    assign deb_now_c  = tick_q ? deb_next : deb;
    assign deb_c      = deb[17:16];
    assign deb_c_next = deb_next[17:16];

    always_comb begin : joy_merge
        joy1_d = deb_now_c[7:0] & {2'b11, kbd_joy};
        joy2_d = deb_now_c[15:8];
    end

    // Each coin: a debounced press while idle starts a COIN_HOLD_SCANS-long low pulse.
    always_comb begin : coin_stretch
        coin_d     = coin_q;
        coin_cnt_d = coin_cnt_q;
        if (tick_q) begin
            for (int i = 0; i < 2; i++) begin
                if (coin_cnt_q[i] != '0) begin
                    coin_cnt_d[i] = coin_cnt_q[i] - CW'(1);
                    if (coin_cnt_q[i] == CW'(1)) begin
                        coin_d[i] = 1'b1;
                    end
                end else if (deb_c[i] && !deb_c_next[i]) begin
                    coin_cnt_d[i] = CW'(COIN_HOLD_SCANS);
                    coin_d[i]     = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= P1_WAIT;
            cnt_q      <= '0;
            jselect_q  <= 1'b0;
            raw1_q     <= JOY_IDLE;
            raw2_q     <= JOY_IDLE;
            rawc_q     <= COIN_IDLE;
            tick_q     <= 1'b0;
            joy1_q     <= JOY_IDLE;
            joy2_q     <= JOY_IDLE;
            coin_q     <= COIN_IDLE;
            coin_cnt_q <= '{default: '0};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            jselect_q  <= jselect_d;
            raw1_q     <= raw1_d;
            raw2_q     <= raw2_d;
            rawc_q     <= rawc_d;
            tick_q     <= tick_d;
            joy1_q     <= joy1_d;
            joy2_q     <= joy2_d;
            coin_q     <= coin_d;
            coin_cnt_q <= coin_cnt_d;
        end
    end

    assign JSELECT   = jselect_q;
    assign joystick1 = joy1_q;
    assign joystick2 = joy2_q;
    assign coin      = coin_q;
    assign scan_tick = tick_q;

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Bench for jamma_input_scanner: directed and random scans against a per-scan reference model.
module tb_jamma_input_scanner;
    import jamma_pkg::*;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned DEB    = 3;
    localparam int unsigned HOLD   = 8;
    localparam int unsigned PERIOD = scan_period(SETTLE);

    logic       CLK = 1'b0;
    logic       reset;
    logic [7:0] p1_word, p2_word, JJOY;
    logic [1:0] JCOIN;
    logic [5:0] kbd_joy;
    logic       JSELECT;
    logic [7:0] joystick1, joystick2;
    logic [1:0] coin;
    logic       scan_tick;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Reference model state: last DEB scan samples, debounced word, coin pulse scans remaining.
    logic [17:0] hist_m[$];
    logic [17:0] deb_m;
    int          rem_m[2];

    // The physical mux: JSELECT picks which player's switches appear on JJOY.
    assign JJOY = JSELECT ? p2_word : p1_word;

    always #5 CLK = ~CLK;

    jamma_input_scanner #(
        .SETTLE_CYCLES  (SETTLE),
        .DEBOUNCE_SCANS (DEB),
        .COIN_HOLD_SCANS(HOLD)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .JJOY     (JJOY),
        .JCOIN    (JCOIN),
        .kbd_joy  (kbd_joy),
        .JSELECT  (JSELECT),
        .joystick1(joystick1),
        .joystick2(joystick2),
        .coin     (coin),
        .scan_tick(scan_tick)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cycle);
        end
    endtask

    task automatic model_reset();
        hist_m = {};
        for (int i = 0; i < int'(DEB); i++) hist_m.push_back('1);
        deb_m = '1;
        rem_m = '{0, 0};
        cycle = 0;
    endtask

    // Advance one clock and check the mux select and the scan strobe against the cycle count.
    task automatic tick_clk();
        @(posedge CLK);
        @(negedge CLK);
        cycle++;
        check("jselect", 8'(JSELECT), 8'((cycle % PERIOD) >= (SETTLE + 1)));
        check("scan_tick", 8'(scan_tick), 8'((cycle % PERIOD) == 0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        model_reset();
        check("rst_joystick1", joystick1, 8'hFF);
        check("rst_joystick2", joystick2, 8'hFF);
        check("rst_coin", 8'(coin), 8'h03);
        check("rst_jselect", 8'(JSELECT), 8'h00);
        check("rst_scan_tick", 8'(scan_tick), 8'h00);
    endtask

    // One full scan with inputs held; outputs from the previous scan are checked on its first clock.
    task automatic run_scan(input logic [7:0] w1, input logic [7:0] w2,
                            input logic [1:0] jc, input logic [5:0] kb);
        logic [17:0] samp, all_and, all_or, stable, prev;
        p1_word = w1;
        p2_word = w2;
        JCOIN   = jc;
        kbd_joy = kb;
        tick_clk();
        check("joystick1", joystick1, deb_m[7:0] & {2'b11, kb});
        check("joystick2", joystick2, deb_m[15:8]);
        check("coin", 8'(coin), 8'({rem_m[1] == 0, rem_m[0] == 0}));
        repeat (PERIOD - 1) tick_clk();
        samp = {jc, w2, w1};
        hist_m.push_back(samp);
        void'(hist_m.pop_front());
        all_and = '1;
        all_or  = '0;
        foreach (hist_m[i]) begin
            all_and &= hist_m[i];
            all_or  |= hist_m[i];
        end
        stable = ~(all_and ^ all_or);
        prev   = deb_m;
        deb_m  = (stable & all_and) | (~stable & deb_m);
        for (int i = 0; i < 2; i++) begin
            if (rem_m[i] > 0) rem_m[i]--;
            else if (prev[16+i] && !deb_m[16+i]) rem_m[i] = int'(HOLD);
        end
    endtask

    // Start a scan, then pull reset for one clock while the player-2 settle is in progress.
    task automatic mid_reset(input logic [7:0] w1, input logic [7:0] w2,
                             input logic [1:0] jc, input logic [5:0] kb);
        p1_word = w1;
        p2_word = w2;
        JCOIN   = jc;
        kbd_joy = kb;
        repeat (SETTLE + 3) tick_clk();
        do_reset();
    endtask

    initial begin
        logic [7:0] r1, r2;
        logic [1:0] rc;
        logic [5:0] rk;
        p1_word = 8'hFF;
        p2_word = 8'hFF;
        JCOIN   = 2'b11;
        kbd_joy = 6'h3F;

        // Idle after reset
        do_reset();
        repeat (4) run_scan(8'hFF, 8'hFF, 2'b11, 6'h3F);

        // Player-2 bit0 pressed from reset: only joystick2 follows
        do_reset();
        repeat (5) run_scan(8'hFF, 8'hFE, 2'b11, 6'h3F);
        check("p2_bit0_joystick2", joystick2, 8'hFE);
        check("p2_bit0_joystick1", joystick1, 8'hFF);

        // Player-1 bit3: a 2-scan glitch is rejected, a 3-scan press is accepted
        do_reset();
        repeat (2) run_scan(8'hF7, 8'hFF, 2'b11, 6'h3F);
        repeat (4) run_scan(8'hFF, 8'hFF, 2'b11, 6'h3F);
        repeat (4) run_scan(8'hF7, 8'hFF, 2'b11, 6'h3F);
        run_scan(8'hFF, 8'hFF, 2'b11, 6'h3F);

        // Keyboard joystick merges without debounce
        run_scan(8'hFF, 8'hFF, 2'b11, 6'b111110);
        run_scan(8'hFF, 8'hFF, 2'b11, 6'h3F);

        // Coin 0 held long, released, pressed again; then both coins together
        repeat (4) run_scan(8'hFF, 8'hFF, 2'b11, 6'h3F);
        repeat (20) run_scan(8'hFF, 8'hFF, 2'b10, 6'h3F);
        repeat (4) run_scan(8'hFF, 8'hFF, 2'b11, 6'h3F);
        repeat (12) run_scan(8'hFF, 8'hFF, 2'b10, 6'h3F);
        repeat (4) run_scan(8'hFF, 8'hFF, 2'b11, 6'h3F);
        repeat (12) run_scan(8'hFF, 8'hFF, 2'b00, 6'h3F);

        // Reset during P2_WAIT with bits held low; coin pulse and outputs restart cleanly
        repeat (4) run_scan(8'h7E, 8'hBD, 2'b01, 6'h3F);
        mid_reset(8'h7E, 8'hBD, 2'b01, 6'h3F);
        repeat (4) run_scan(8'h7E, 8'hBD, 2'b01, 6'h3F);
        check("post_reset_joystick1", joystick1, 8'h7E);
        check("post_reset_joystick2", joystick2, 8'hBD);

        // Random bursts of held inputs
        r1 = 8'hFF; r2 = 8'hFF; rc = 2'b11; rk = 6'h3F;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                r1 = 8'($urandom) | 8'($urandom);
                r2 = 8'($urandom) | 8'($urandom);
                rc = 2'($urandom);
            end
            if ($urandom_range(0, 3) == 0) rk = 6'($urandom) | 6'($urandom);
            run_scan(r1, r2, rc, rk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
